// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: random wait, go cue, BCD millisecond timing, best-time tracking.
// Define HISCORE_CLR_EN to add the clr_hi input that resets the best time from IDLE or RESULT.
module reaction_timer_ctrl #(
  parameter int CLKS_PER_MS = 50000,
  parameter int WAIT_MIN_MS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        show_hi,
`ifdef HISCORE_CLR_EN
  input  logic        clr_hi,
`endif
  output logic [3:0]  ones,
  output logic [3:0]  tenths,
  output logic [3:0]  hundreths,
  output logic [3:0]  thousandths,
  output logic [15:0] hiscore,
  output logic        hienable,
  output logic        go_led,
  output logic        false_start
);

  localparam int PW = $clog2(CLKS_PER_MS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);
  localparam int DW_RAW = $clog2(WAIT_MIN_MS + 1024);
  localparam int DW = (DW_RAW < 11) ? 11 : DW_RAW;
  localparam logic [15:0] BCD_MAX = 16'h9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    TIMING = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t         state_q;
  logic [9:0]     lfsr_q;
  logic [PW-1:0]  presc_q;
  logic [PW-1:0]  presc_d;
  logic [DW-1:0]  delayMs_q;
  logic [15:0]    digits_q;
  logic [15:0]    digits_d;
  logic [15:0]    hiscore_q;
  logic           hienable_q;
  logic           goLed_q;
  logic           falseStart_q;
  logic           tick;
  logic           resultView;

  // Four-digit BCD increment; each digit wraps 9 -> 0 and carries into the next one up.
  function automatic logic [15:0] bcdInc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    tick       = (presc_q == PRESC_LAST);
    presc_d    = tick ? '0 : presc_q + 1'b1;
    digits_d   = bcdInc(digits_q);
    resultView = (state_q == IDLE) || (state_q == RESULT);
  end

  // Round sequencer; every output is a register updated here so nothing leaks combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= 10'h001;
      presc_q      <= '0;
      delayMs_q    <= '0;
      digits_q     <= '0;
      hiscore_q    <= BCD_MAX;
      hienable_q   <= 1'b0;
      goLed_q      <= 1'b0;
      falseStart_q <= 1'b0;
    end else begin
      lfsr_q     <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      presc_q    <= presc_d;
      hienable_q <= show_hi && resultView;

      case (state_q)
        IDLE, RESULT: begin
          if (start) begin
            state_q      <= WAIT;
            delayMs_q    <= DW'(WAIT_MIN_MS) + DW'(lfsr_q);
            digits_q     <= '0;
            falseStart_q <= 1'b0;
            presc_q      <= '0;
          end
        end

        WAIT: begin
          if (stop) begin
            state_q      <= RESULT;
            digits_q     <= BCD_MAX;
            falseStart_q <= 1'b1;
          end else if (tick) begin
            if (delayMs_q == '0) begin
              state_q <= TIMING;
              goLed_q <= 1'b1;
              presc_q <= '0;
            end else begin
              delayMs_q <= delayMs_q - 1'b1;
            end
          end
        end

        TIMING: begin
          // A stop coinciding with a tick freezes the pre-tick value.
          if (stop) begin
            state_q <= RESULT;
            goLed_q <= 1'b0;
            if (digits_q < hiscore_q) begin
              hiscore_q <= digits_q;
            end
          end else if (tick) begin
            if (digits_q == BCD_MAX) begin
              state_q <= RESULT;
              goLed_q <= 1'b0;
            end else begin
              digits_q <= digits_d;
            end
          end
        end

        default: state_q <= IDLE;
      endcase

`ifdef HISCORE_CLR_EN
      if (clr_hi && resultView) begin
        hiscore_q <= BCD_MAX;
      end
`endif
    end
  end

  assign ones        = digits_q[15:12];
  assign tenths      = digits_q[11:8];
  assign hundreths   = digits_q[7:4];
  assign thousandths = digits_q[3:0];
  assign hiscore     = hiscore_q;
  assign hienable    = hienable_q;
  assign go_led      = goLed_q;
  assign false_start = falseStart_q;

endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
Game controller for the 4-digit BCD seconds display (X.XXX s) and its high-score select. Sequences a reaction-time round: random wait, "go" cue, millisecond BCD timing until the player presses stop, then result hold and best-time tracking. Its digit outputs and hienable select drive the existing BCD seven-segment decoder directly.

Parameters:
CLKS_PER_MS, 50000, clock cycles per 1 ms tick (50 MHz board clock); must be >= 2.
WAIT_MIN_MS, 1000, minimum random wait before go cue, in ms.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  one-cycle pulse (pre-debounced); begins a round
stop  input  1  one-cycle pulse (pre-debounced); player reaction
show_hi  input  1  level; request high-score display
ones  output  4  BCD seconds digit
tenths  output  4  BCD 0.1 s digit
hundreths  output  4  BCD 0.01 s digit
thousandths  output  4  BCD 0.001 s digit
hiscore  output  16  packed BCD best time {s,0.1,0.01,0.001}
hienable  output  1  1 = decoder shows hiscore
go_led  output  1  go cue, high only in TIMING
false_start  output  1  high in RESULT when round ended by early stop

Behaviour:
- Reset (sync, overrides all): state IDLE; all digits 0; hiscore 16'h9999; hienable 0; go_led 0; false_start 0; prescaler 0; LFSR 10'h001.
- LFSR: 10-bit maximal (taps 10,7), advances every clk except reset; never 0.
- ms tick: prescaler counts 0..CLKS_PER_MS-1, tick asserted on the cycle it equals CLKS_PER_MS-1; prescaler cleared on every state entry into WAIT or TIMING.
- States: IDLE, WAIT, TIMING, RESULT (2-bit encoding).
- IDLE: start -> WAIT; load delay_ms = WAIT_MIN_MS + LFSR value (11+ bit counter sized for WAIT_MIN_MS+1023); clear digits and false_start.
- WAIT: each tick decrements delay_ms; when delay_ms==0 and tick -> TIMING, go_led=1 from the next cycle. stop in WAIT -> RESULT, digits forced to 9/9/9/9, false_start=1, no hiscore update.
- TIMING: each tick increments 4-digit BCD counter (thousandths carries into hundreths into tenths into ones; digit 9 wraps to 0 with carry). At 9.999 the next tick does not wrap: saturate, -> RESULT (timeout, no hiscore update). stop -> RESULT next edge, digits frozen. stop and tick same cycle: stop wins, tick discarded.
- Entry to RESULT from stop in TIMING: if packed {ones,tenths,hundreths,thousandths} < hiscore (unsigned compare of packed BCD is valid), hiscore loads packed value on the same edge. Tie: no update.
- RESULT: holds digits; start -> WAIT (same load as IDLE). stop ignored.
- start ignored in WAIT and TIMING. show_hi sampled: hienable registered = show_hi when state is IDLE or RESULT, else 0 (one-cycle latency).
- go_led = 1 only in TIMING; deasserts on the edge leaving TIMING.
- Digit outputs are registers; no combinational path input->output.

Optional Feature:
HISCORE_CLR_EN: when defined, adds input port clr_hi (1 bit, level). clr_hi high while in IDLE or RESULT sets hiscore to 16'h9999 next edge; ignored in WAIT/TIMING; lower priority than reset, higher than a same-cycle hiscore update. When undefined, port absent and hiscore clears only on reset.

Test Plan:
Reset with CLKS_PER_MS=4, WAIT_MIN_MS=2 -> digits 0, hiscore 16'h9999, hienable 0, go_led 0, state IDLE.
start, wait for go_led, stop after 253 ticks -> digits 0/2/5/3, hiscore 16'h0253, false_start 0, go_led low next cycle.
Second round stopping at 310 ticks -> digits 0/3/1/0, hiscore stays 16'h0253; third round at 0.253 (tie) -> no change.
stop pulse during WAIT -> RESULT, digits 9/9/9/9, false_start 1, hiscore unchanged.
No stop in TIMING for 9999 ticks -> digits saturate 9/9/9/9, RESULT, hiscore unchanged; stop and tick in same cycle at 0.099 -> result 0.099 not 0.100.
show_hi=1 in RESULT -> hienable 1 one cycle later; start -> hienable 0 in WAIT; with HISCORE_CLR_EN, clr_hi in RESULT -> hiscore 16'h9999.
